// File: rtl/game_pkg.sv
// Shared types and defaults for the symbol-counting game round sequencer.
package game_pkg;

  localparam int SYM_W = 32;
  localparam int CNT_W = 8;

  localparam logic [SYM_W-1:0] SYMGEN_MAX_INIT_DEF = 32'd100_000_000;
  localparam logic [SYM_W-1:0] SYMGEN_STEP_DEF     = 32'd20_000_000;
  localparam logic [SYM_W-1:0] SYMGEN_MIN_DEF      = 32'd25_000_000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_PLAY,
    S_ANSWER,
    S_JUDGE,
    S_RESULT,
    S_DONE
  } state_t;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/game_round_sequencer_sec_timer.sv
// Seconds timer: counts Tick1Hz enables since the last clear and flags the
// tick on which the count reaches the selected limit.
module sec_timer
  import game_pkg::*;
(
  input  logic             Clk100M,
  input  logic             Reset,
  input  logic             clear,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge Clk100M) begin
    if (Reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

  assign done = tick && !clear && (count == limit - 1'b1);

endmodule

// File: rtl/game_round_sequencer.sv
// Round controller: launch -> play -> answer window -> judge -> result hold, NUM_ROUNDS times.
// Optional STREAK_BONUS_EN adds a streak[1:0] port and +2 scoring from the third straight correct answer.
//
// state    | meaning
// S_IDLE   | waiting for startBtn, outputs at rest
// S_LAUNCH | one cycle; gameSig pulses on the following cycle
// S_PLAY   | game period running, waiting for periodDone
// S_ANSWER | answer window open, timeout counted in Tick1Hz
// S_JUDGE  | one cycle; compare answer and update score
// S_RESULT | hold result for RESULT_HOLD_S ticks
// S_DONE   | all rounds played, gameOver high
module game_round_sequencer
  import game_pkg::*;
#(
  parameter int               NUM_ROUNDS       = 3,
  parameter int               ANSWER_TIMEOUT_S = 10,
  parameter int               RESULT_HOLD_S    = 2,
  parameter logic [SYM_W-1:0] SYMGEN_MAX_INIT  = SYMGEN_MAX_INIT_DEF,
  parameter logic [SYM_W-1:0] SYMGEN_STEP      = SYMGEN_STEP_DEF,
  parameter logic [SYM_W-1:0] SYMGEN_MIN       = SYMGEN_MIN_DEF
) (
  input  logic             Clk100M,
  input  logic             Reset,
  input  logic             Tick1Hz,
  input  logic             startBtn,
  input  logic             periodDone,
  input  logic [CNT_W-1:0] numSpecial,
  input  logic             answerValid,
  input  logic [CNT_W-1:0] playerAnswer,
  output logic             gameSig,
  output logic [SYM_W-1:0] symGenMax,
  output logic [CNT_W-1:0] roundNum,
  output logic [CNT_W-1:0] score,
  output logic             answerOpen,
  output logic             resultValid,
  output logic             resultCorrect,
  output logic             gameOver
`ifdef STREAK_BONUS_EN
  ,
  output logic [1:0]       streak
`endif
);

  localparam logic [CNT_W-1:0] ANS_LIM    = CNT_W'(ANSWER_TIMEOUT_S);
  localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(RESULT_HOLD_S);
  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] expected, answer_q, tmr_limit;
  logic             timed_out, tmr_clear, tmr_done;
  logic             start_game, correct;
  logic [1:0]       inc;
  logic [SYM_W:0]   sym_diff;
  logic [SYM_W-1:0] sym_next;

  assign start_game = (state == S_IDLE || state == S_DONE) && startBtn;
  assign correct    = !timed_out && (answer_q == expected);

  // Borrow out of the 33-bit subtraction means underflow; clamp like any value below the floor.
  assign sym_diff = {1'b0, symGenMax} - {1'b0, SYMGEN_STEP};
  assign sym_next = (sym_diff[SYM_W] || sym_diff[SYM_W-1:0] < SYMGEN_MIN) ? SYMGEN_MIN
                                                                         : sym_diff[SYM_W-1:0];

  // One timer serves both windows; it sits cleared in every other state.
  assign tmr_clear = (state != S_ANSWER) && (state != S_RESULT);
  assign tmr_limit = (state == S_RESULT) ? HOLD_LIM : ANS_LIM;

  sec_timer u_sec_timer (
    .Clk100M (Clk100M),
    .Reset   (Reset),
    .clear   (tmr_clear),
    .tick    (Tick1Hz),
    .limit   (tmr_limit),
    .done    (tmr_done)
  );

  always_ff @(posedge Clk100M) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (startBtn) state_nxt = S_LAUNCH;
      S_LAUNCH:       state_nxt = S_PLAY;
      S_PLAY:         if (periodDone) state_nxt = S_ANSWER;
      S_ANSWER:       if (answerValid || tmr_done) state_nxt = S_JUDGE;
      S_JUDGE:        state_nxt = S_RESULT;
      S_RESULT:       if (tmr_done) state_nxt = (roundNum == LAST_ROUND) ? S_DONE : S_LAUNCH;
      default:        state_nxt = S_IDLE;
    endcase
  end

`ifdef STREAK_BONUS_EN
  assign inc = (streak >= 2'd2) ? 2'd2 : 2'd1;

  always_ff @(posedge Clk100M) begin
    if (Reset || start_game) begin
      streak <= 2'd0;
    end else if (state == S_JUDGE) begin
      if (!correct)            streak <= 2'd0;
      else if (streak != 2'd3) streak <= streak + 2'd1;
    end
  end
`else
  assign inc = 2'd1;
`endif

  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      gameSig       <= 1'b0;
      symGenMax     <= SYMGEN_MAX_INIT;
      roundNum      <= '0;
      score         <= '0;
      answerOpen    <= 1'b0;
      resultValid   <= 1'b0;
      resultCorrect <= 1'b0;
      gameOver      <= 1'b0;
      expected      <= '0;
      answer_q      <= '0;
      timed_out     <= 1'b0;
    end else begin
      gameSig     <= (state == S_LAUNCH);
      answerOpen  <= (state_nxt == S_ANSWER);
      gameOver    <= (state_nxt == S_DONE);
      resultValid <= (state == S_JUDGE);
      if (start_game) begin
        score     <= '0;
        roundNum  <= 8'd1;
        symGenMax <= SYMGEN_MAX_INIT;
      end
      if (state == S_PLAY && periodDone) expected <= numSpecial;
      // An answer landing on the terminal tick still counts as answered.
      if (state == S_ANSWER) begin
        if (answerValid) begin
          answer_q  <= playerAnswer;
          timed_out <= 1'b0;
        end else if (tmr_done) begin
          timed_out <= 1'b1;
        end
      end
      if (state == S_JUDGE) begin
        resultCorrect <= correct;
        if (correct) score <= sat_add(score, inc);
      end
      if (state == S_RESULT && tmr_done && roundNum != LAST_ROUND) begin
        roundNum  <= roundNum + 1'b1;
        symGenMax <= sym_next;
      end
    end
  end

endmodule

// File: tb/tb_game_round_sequencer.sv
// Directed bench for game_round_sequencer; the STREAK_BONUS_EN section runs only when that macro is defined.
module tb_game_round_sequencer;
  import game_pkg::*;

  logic        Clk100M = 1'b0;
  logic        Reset = 1'b1, Tick1Hz = 1'b0, startBtn = 1'b0, periodDone = 1'b0, answerValid = 1'b0;
  logic [7:0]  numSpecial = 8'd0, playerAnswer = 8'd0;

  logic        gameSig, answerOpen, resultValid, resultCorrect, gameOver;
  logic [31:0] symGenMax;
  logic [7:0]  roundNum, score;

  logic        b_gameSig, b_answerOpen, b_resultValid, b_resultCorrect, b_gameOver;
  logic [31:0] b_symGenMax;
  logic [7:0]  b_roundNum, b_score;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk100M = ~Clk100M;

`ifdef STREAK_BONUS_EN
  logic [1:0]  streak, b_streak, s_streak;
  logic        s_gameSig, s_answerOpen, s_resultValid, s_resultCorrect, s_gameOver;
  logic [31:0] s_symGenMax;
  logic [7:0]  s_roundNum, s_score;
`endif

  game_round_sequencer dut (
    .Clk100M(Clk100M), .Reset(Reset), .Tick1Hz(Tick1Hz), .startBtn(startBtn),
    .periodDone(periodDone), .numSpecial(numSpecial), .answerValid(answerValid),
    .playerAnswer(playerAnswer), .gameSig(gameSig), .symGenMax(symGenMax),
    .roundNum(roundNum), .score(score), .answerOpen(answerOpen),
    .resultValid(resultValid), .resultCorrect(resultCorrect), .gameOver(gameOver)
`ifdef STREAK_BONUS_EN
    , .streak(streak)
`endif
  );

  game_round_sequencer #(.SYMGEN_STEP(32'd40_000_000)) dut_step40 (
    .Clk100M(Clk100M), .Reset(Reset), .Tick1Hz(Tick1Hz), .startBtn(startBtn),
    .periodDone(periodDone), .numSpecial(numSpecial), .answerValid(answerValid),
    .playerAnswer(playerAnswer), .gameSig(b_gameSig), .symGenMax(b_symGenMax),
    .roundNum(b_roundNum), .score(b_score), .answerOpen(b_answerOpen),
    .resultValid(b_resultValid), .resultCorrect(b_resultCorrect), .gameOver(b_gameOver)
`ifdef STREAK_BONUS_EN
    , .streak(b_streak)
`endif
  );

`ifdef STREAK_BONUS_EN
  game_round_sequencer #(.NUM_ROUNDS(4)) dut_r4 (
    .Clk100M(Clk100M), .Reset(Reset), .Tick1Hz(Tick1Hz), .startBtn(startBtn),
    .periodDone(periodDone), .numSpecial(numSpecial), .answerValid(answerValid),
    .playerAnswer(playerAnswer), .gameSig(s_gameSig), .symGenMax(s_symGenMax),
    .roundNum(s_roundNum), .score(s_score), .answerOpen(s_answerOpen),
    .resultValid(s_resultValid), .resultCorrect(s_resultCorrect), .gameOver(s_gameOver),
    .streak(s_streak)
  );
`endif

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk100M);
      #1;
    end
  endtask

  task automatic start_game();
    startBtn = 1'b1;
    cyc();
    startBtn = 1'b0;
    check_val("gamesig_early", gameSig, 1'b0);
    cyc();
    check_val("gamesig_launch", gameSig, 1'b1);
  endtask

  task automatic wait_launch();
    int k = 0;
    while (gameSig !== 1'b1 && k < 40) begin
      cyc();
      k++;
    end
    check_val("launch_wait", gameSig, 1'b1);
  endtask

  task automatic play(input logic [7:0] ns);
    periodDone = 1'b1;
    numSpecial = ns;
    cyc();
    periodDone = 1'b0;
    check_val("answer_open", answerOpen, 1'b1);
  endtask

  task automatic answer(input logic [7:0] a, input logic exp_ok, input logic [7:0] exp_score);
    answerValid  = 1'b1;
    playerAnswer = a;
    cyc();
    answerValid = 1'b0;
    check_val("rv_early", resultValid, 1'b0);
    cyc();
    check_val("rv", resultValid, 1'b1);
    check_val("correct", resultCorrect, exp_ok);
    check_val("score", score, exp_score);
  endtask

  task automatic tick();
    Tick1Hz = 1'b1;
    cyc();
    Tick1Hz = 1'b0;
    cyc();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    cyc(3);
    Reset = 1'b0;
    check_val("rst_gamesig", gameSig, 1'b0);
    check_val("rst_symgen", symGenMax, 32'd100_000_000);
    check_val("rst_round", roundNum, 8'd0);
    check_val("rst_score", score, 8'd0);
    check_val("rst_open", answerOpen, 1'b0);
    check_val("rst_rv", resultValid, 1'b0);
    check_val("rst_rc", resultCorrect, 1'b0);
    check_val("rst_over", gameOver, 1'b0);

    // Game 1, round 1: correct answer
    start_game();
    check_val("r1_round", roundNum, 8'd1);
    check_val("r1_sym", symGenMax, 32'd100_000_000);
    check_val("r1_sym40", b_symGenMax, 32'd100_000_000);
    play(8'd5);
    answer(8'd5, 1'b1, 8'd1);
    cyc();
    check_val("rv_pulse", resultValid, 1'b0);
    tick();
    check_val("hold_round", roundNum, 8'd1);
    tick();
    check_val("r2_round", roundNum, 8'd2);
    check_val("r2_sym", symGenMax, 32'd80_000_000);
    check_val("r2_sym40", b_symGenMax, 32'd60_000_000);
    wait_launch();

    // Round 2: wrong answer
    play(8'd7);
    answer(8'd4, 1'b0, 8'd1);
    tick();
    tick();
    check_val("r3_round", roundNum, 8'd3);
    check_val("r3_sym", symGenMax, 32'd60_000_000);
    check_val("r3_sym40", b_symGenMax, 32'd25_000_000);
    wait_launch();

    // Round 3: timeout
    play(8'd3);
    for (int i = 0; i < 9; i++) tick();
    check_val("to_open9", answerOpen, 1'b1);
    check_val("to_rv9", resultValid, 1'b0);
    Tick1Hz = 1'b1;
    cyc();
    Tick1Hz = 1'b0;
    check_val("to_closed", answerOpen, 1'b0);
    cyc();
    check_val("to_rv", resultValid, 1'b1);
    check_val("to_rc", resultCorrect, 1'b0);
    check_val("to_score", score, 8'd1);
    tick();
    check_val("over_early", gameOver, 1'b0);
    tick();
    check_val("over", gameOver, 1'b1);
    check_val("over40", b_gameOver, 1'b1);
    check_val("over_round", roundNum, 8'd3);

    // Game 2 from DONE: answer on the terminal tick wins
    start_game();
    check_val("g2_score", score, 8'd0);
    check_val("g2_round", roundNum, 8'd1);
    check_val("g2_sym", symGenMax, 32'd100_000_000);
    check_val("g2_over", gameOver, 1'b0);
    play(8'd9);
    for (int i = 0; i < 9; i++) tick();
    Tick1Hz      = 1'b1;
    answerValid  = 1'b1;
    playerAnswer = 8'd9;
    cyc();
    Tick1Hz     = 1'b0;
    answerValid = 1'b0;
    cyc();
    check_val("tie_rv", resultValid, 1'b1);
    check_val("tie_rc", resultCorrect, 1'b1);
    check_val("tie_score", score, 8'd1);
    tick();
    tick();
    wait_launch();

    // Reset in the middle of the answer window
    play(8'd2);
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    check_val("mr_round", roundNum, 8'd0);
    check_val("mr_score", score, 8'd0);
    check_val("mr_open", answerOpen, 1'b0);
    check_val("mr_sym", symGenMax, 32'd100_000_000);
    check_val("mr_rc", resultCorrect, 1'b0);
    check_val("mr_rv", resultValid, 1'b0);
    check_val("mr_gamesig", gameSig, 1'b0);
    cyc(3);
    check_val("mr_gamesig_later", gameSig, 1'b0);
    check_val("mr_idle", roundNum, 8'd0);

    // startBtn during PLAY is ignored
    start_game();
    startBtn = 1'b1;
    cyc();
    startBtn = 1'b0;
    cyc();
    check_val("ign_gamesig", gameSig, 1'b0);
    check_val("ign_round", roundNum, 8'd1);
    play(8'd6);
    answer(8'd6, 1'b1, 8'd1);

`ifdef STREAK_BONUS_EN
    begin
      logic [7:0] exp_sc[4];
      logic [1:0] exp_st[4];
      int k;
      exp_sc = '{8'd1, 8'd2, 8'd4, 8'd6};
      exp_st = '{2'd1, 2'd2, 2'd3, 2'd3};
      Reset = 1'b1;
      cyc();
      Reset = 1'b0;
      start_game();
      for (int r = 0; r < 4; r++) begin
        k = 0;
        while (s_gameSig !== 1'b1 && k < 40) begin
          cyc();
          k++;
        end
        check_val("st_launch", s_gameSig, 1'b1);
        periodDone = 1'b1;
        numSpecial = 8'(r + 3);
        cyc();
        periodDone   = 1'b0;
        answerValid  = 1'b1;
        playerAnswer = 8'(r + 3);
        cyc();
        answerValid = 1'b0;
        cyc();
        check_val("st_score", s_score, exp_sc[r]);
        check_val("st_streak", s_streak, exp_st[r]);
        tick();
        tick();
      end
      check_val("st_over", s_gameOver, 1'b1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
